// File: rtl/bin_thresh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bin_thresh_ctrl
//  Description : Per-frame threshold controller for the Y-to-binary stage.
//                Accumulates the luma of each frame and divides the sum by
//                the pixel count to get the mean. Then forwards either a
//                fixed CPU threshold or (mean + signed offset), clamped.
//                The threshold only changes on the vsync falling edge.
//                Optional macro BIN_THRESH_HYST_EN: in auto mode a new
//                result is applied only if it differs from the current
//                threshold by at least HYST.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_thresh_ctrl #(
    parameter int PIX_W      = 21,
    parameter int DEF_THRESH = 125,
    parameter int HYST       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_de,
    input  logic [7:0] img_y,
    input  logic       cfg_wr,
    input  logic       cfg_auto,
    input  logic [7:0] cfg_thresh,
    input  logic [7:0] cfg_offset,
    output logic [7:0] threshold,
    output logic       thresh_upd,
    output logic [7:0] mean_y,
    output logic       busy,
    output logic       ovr
);

    localparam int         c_SUM_W      = PIX_W + 8;
    localparam logic [7:0] c_DEF_THRESH = 8'(DEF_THRESH);

`ifdef BIN_THRESH_HYST_EN
    localparam bit c_HYST_EN = 1'b1;
`else
    localparam bit c_HYST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_DIV   = 2'd1,
        S_ADJ   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               r_state;

    // vsync edge detection
    logic                 r_vs_d;
    logic                 w_rise;
    logic                 w_fall;

    // shadow configuration
    logic                 r_sh_auto;
    logic [7:0]           r_sh_thresh;
    logic [7:0]           r_sh_off;

    // accumulator
    logic [c_SUM_W-1:0]   r_sum;
    logic [PIX_W-1:0]     r_cnt;
    logic                 r_inval;
    logic                 w_cnt_full;

    // restoring divider
    logic [c_SUM_W-1:0]   r_rem;
    logic [c_SUM_W-1:0]   r_dvs;
    logic [7:0]           r_quo;
    logic [2:0]           r_step;
    logic                 r_skip;
    logic                 w_rem_ge;
    logic [c_SUM_W-1:0]   w_rem_sub;

    // result path
    logic [9:0]           w_adj;
    logic [7:0]           w_clamp;
    logic [7:0]           r_res;
    logic                 r_res_vld;
    logic [8:0]           w_delta;
    logic                 w_hyst_ok;
    logic                 w_overrun;

    // registered outputs
    logic [7:0]           r_threshold;
    logic                 r_upd;
    logic [7:0]           r_mean;
    logic                 r_ovr;

    assign w_rise = pre_frame_vsync & ~r_vs_d;
    assign w_fall = ~pre_frame_vsync & r_vs_d;

    assign w_cnt_full = &r_cnt;

    assign w_rem_ge  = (r_rem >= r_dvs);
    assign w_rem_sub = r_rem - r_dvs;

    // mean + signed offset in 10-bit signed arithmetic, then clamp to 0..255
    assign w_adj   = {2'b00, r_quo} + {{2{r_sh_off[7]}}, r_sh_off};
    assign w_clamp = w_adj[9] ? 8'd0 : (w_adj[8] ? 8'hFF : w_adj[7:0]);

    // distance between the pending auto result and the active threshold
    assign w_delta = (r_res >= r_threshold) ? {1'b0, r_res - r_threshold}
                                            : {1'b0, r_threshold - r_res};
    // with hysteresis disabled every valid result passes
    assign w_hyst_ok = ~c_HYST_EN | (w_delta >= 9'(HYST));

    // a fall while the divider is still working means this frame's result is lost
    assign w_overrun = (r_state == S_DIV) || (r_state == S_ADJ);

    // vsync delay register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d <= 1'b0;
        end else begin
            r_vs_d <= pre_frame_vsync;
        end
    end

    // CPU shadow registers, writable at any time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_auto   <= 1'b0;
            r_sh_thresh <= c_DEF_THRESH;
            r_sh_off    <= 8'd0;
        end else if (cfg_wr) begin
            r_sh_auto   <= cfg_auto;
            r_sh_thresh <= cfg_thresh;
            r_sh_off    <= cfg_offset;
        end
    end

    // frame FSM: accumulate, divide, adjust, hold; frame boundary on vsync fall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ACCUM;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_inval     <= 1'b0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_quo       <= 8'd0;
            r_step      <= 3'd0;
            r_skip      <= 1'b0;
            r_res       <= c_DEF_THRESH;
            r_res_vld   <= 1'b0;
            r_threshold <= c_DEF_THRESH;
            r_upd       <= 1'b0;
            r_mean      <= 8'd0;
            r_ovr       <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (cfg_wr) begin
                r_ovr <= 1'b0;
            end

            if (w_fall) begin
                // frame boundary: load the threshold and restart accumulation
                r_upd     <= 1'b1;
                r_sum     <= '0;
                r_cnt     <= '0;
                r_inval   <= 1'b0;
                r_res_vld <= 1'b0;
                r_state   <= S_ACCUM;
                if (w_overrun) begin
                    r_ovr <= 1'b1;
                end
                if (!r_sh_auto) begin
                    r_threshold <= r_sh_thresh;
                end else if (r_res_vld && !w_overrun && w_hyst_ok) begin
                    r_threshold <= r_res;
                end
            end else begin
                case (r_state)
                    S_ACCUM: begin
                        if (w_rise) begin
                            // freeze the frame totals into the divider
                            r_rem   <= r_sum;
                            r_dvs   <= {1'b0, r_cnt, 7'd0};
                            r_quo   <= 8'd0;
                            r_step  <= 3'd0;
                            r_skip  <= (r_cnt == '0) || r_inval;
                            r_state <= S_DIV;
                        end else if (pre_frame_de && !pre_frame_vsync) begin
                            if (w_cnt_full) begin
                                r_inval <= 1'b1;
                            end else begin
                                r_sum <= r_sum + c_SUM_W'(img_y);
                                r_cnt <= r_cnt + PIX_W'(1);
                            end
                        end
                    end
                    S_DIV: begin
                        // one quotient bit per cycle, MSB first; the mean never exceeds 255
                        if (w_rem_ge) begin
                            r_rem <= w_rem_sub;
                            r_quo <= {r_quo[6:0], 1'b1};
                        end else begin
                            r_quo <= {r_quo[6:0], 1'b0};
                        end
                        r_dvs  <= r_dvs >> 1;
                        r_step <= r_step + 3'd1;
                        if (r_step == 3'd7) begin
                            r_state <= S_ADJ;
                        end
                    end
                    S_ADJ: begin
                        // empty or invalid frames keep the previous mean and result
                        if (!r_skip) begin
                            r_mean    <= r_quo;
                            r_res     <= w_clamp;
                            r_res_vld <= 1'b1;
                        end
                        r_state <= S_HOLD;
                    end
                    S_HOLD: begin
                        r_state <= S_HOLD;
                    end
                    default: begin
                        r_state <= S_ACCUM;
                    end
                endcase
            end
        end
    end

    assign threshold  = r_threshold;
    assign thresh_upd = r_upd;
    assign mean_y     = r_mean;
    assign ovr        = r_ovr;
    assign busy       = (r_state == S_DIV) || (r_state == S_ADJ);

endmodule
`default_nettype wire
